// File: rtl/adc_par_reader.sv
// adc_par_reader
//
// Drives a parallel-bus simultaneous-sampling ADC. It performs two jobs:
// 1. Writes a 32-bit configuration value as two bus words.
// 2. Starts a conversion on every channel pair, waits for the BUSY pulse,
//    then reads 2*NUM_PAIRS words back.
//
// Ports
//   CLK, RST             clock, asynchronous active-high reset
//   cfg_req, cfg_word    start a configuration write with this value
//   conv_req             start a conversion plus a frame read
//   ctrl_busy            controller is not idle
//   CS_N, WR_N, RD_N     ADC select / write strobe / read strobe (active low)
//   CONVST               convert start, one bit per channel pair
//   BUSY                 ADC busy (asynchronous to CLK)
//   DB_I, DB_O, DB_OE    bidirectional data bus, split into in/out/enable
//   smp_valid            one-cycle strobe; smp_data/smp_idx hold the word
//   smp_data, smp_idx    sample value and its word index within the frame
//   frame_done           one-cycle pulse after the last word of a frame
//   timeout_err          one-cycle pulse when BUSY never completes
//
// Request/strobe semantics:
// - cfg_req and conv_req are sampled only while the FSM is in IDLE.
// - cfg_req has priority over conv_req.
// - A request made in any other state is dropped, not queued.
// - smp_valid, frame_done and timeout_err are single-cycle strobes with no
//   backpressure.
// - The FSM state is held in state_q so that checkers can bind to it.
module adc_par_reader #(
   parameter int NUM_PAIRS   = 4,
   parameter int DATA_W      = 16,
   parameter int CONVST_CYC  = 4,
   parameter int WRL_CYC     = 3,
   parameter int RDL_CYC     = 3,
   parameter int RDH_CYC     = 2,
   parameter int TIMEOUT_CYC = 1024,
   localparam int N_WORDS    = 2 * NUM_PAIRS,
   localparam int IDX_W      = (N_WORDS > 2) ? $clog2(N_WORDS) : 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cfg_req,
   input  logic [31:0]          cfg_word,
   input  logic                 conv_req,
   output logic                 ctrl_busy,
   output logic                 CS_N,
   output logic                 WR_N,
   output logic                 RD_N,
   output logic [NUM_PAIRS-1:0] CONVST,
   input  logic                 BUSY,
   input  logic [DATA_W-1:0]    DB_I,
   output logic [DATA_W-1:0]    DB_O,
   output logic                 DB_OE,
   output logic                 smp_valid,
   output logic [DATA_W-1:0]    smp_data,
   output logic [IDX_W-1:0]     smp_idx,
   output logic                 frame_done,
   output logic                 timeout_err
);

   // One phase counter serves every timed state.
   // It is therefore sized for the longest phase.
   localparam int PH_MAX0 = (CONVST_CYC > WRL_CYC) ? CONVST_CYC : WRL_CYC;
   localparam int PH_MAX1 = (RDL_CYC > RDH_CYC) ? RDL_CYC : RDH_CYC;
   localparam int PH_MAX  = (PH_MAX0 > PH_MAX1) ? PH_MAX0 : PH_MAX1;
   localparam int PH_W    = $clog2(PH_MAX + 1);
   localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

   localparam logic [PH_W-1:0]  CONV_LAST = PH_W'(CONVST_CYC - 1);
   localparam logic [PH_W-1:0]  WRL_LAST  = PH_W'(WRL_CYC - 1);
   localparam logic [PH_W-1:0]  RDL_LAST  = PH_W'(RDL_CYC - 1);
   localparam logic [PH_W-1:0]  RDH_LAST  = PH_W'(RDH_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE, WR_LO, WR_HI, CONV, WAIT_HI, WAIT_LO, RD_LO, RD_HI
   } state_t;

   state_t               state_q, state_d;
   logic [PH_W-1:0]      ph_cnt;
   logic [TO_W-1:0]      to_cnt;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 word_sel_q, word_sel_d;
   logic [31:0]          cfg_q, cfg_d;
   logic                 busy_s1, busy_s2;
   logic                 cap, done, to_hit;
   logic                 cs_n_d, wr_n_d, rd_n_d, oe_d;
   logic [NUM_PAIRS-1:0] convst_d;
   logic [DATA_W-1:0]    db_o_d;

   // Next-state logic and output decode.
   // All pin values are decoded from the *next* state and then registered.
   // As a result, every strobe and select is a flop output that changes
   // in step with state_q.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_sel_d = word_sel_q;
      cfg_d      = cfg_q;
      cap        = 1'b0;
      done       = 1'b0;
      to_hit     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cfg_req) begin
               state_d    = WR_LO;
               cfg_d      = cfg_word;
               word_sel_d = 1'b0;
            end else if (conv_req) begin
               state_d = CONV;
            end
         end
         WR_LO: if (ph_cnt == WRL_LAST) state_d = WR_HI;
         WR_HI: begin
            if (ph_cnt == RDH_LAST) begin
               if (word_sel_q) begin
                  state_d = IDLE;
               end else begin
                  state_d    = WR_LO;
                  word_sel_d = 1'b1;
               end
            end
         end
         CONV: if (ph_cnt == CONV_LAST) state_d = WAIT_HI;
         // In both wait states the BUSY edge takes priority over a timeout
         // that lands in the same cycle.
         WAIT_HI: begin
            if (busy_s2) begin
               state_d = WAIT_LO;
            end else if (to_cnt == TO_LAST) begin
               state_d = IDLE;
               to_hit  = 1'b1;
            end
         end
         WAIT_LO: begin
            if (!busy_s2) begin
               state_d = RD_LO;
               idx_d   = '0;
            end else if (to_cnt == TO_LAST) begin
               state_d = IDLE;
               to_hit  = 1'b1;
            end
         end
         RD_LO: begin
            if (ph_cnt == RDL_LAST) begin
               state_d = RD_HI;
               cap     = 1'b1;
            end
         end
         RD_HI: begin
            if (ph_cnt == RDH_LAST) begin
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done    = 1'b1;
               end else begin
                  state_d = RD_LO;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      cs_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      rd_n_d   = 1'b1;
      oe_d     = 1'b0;
      convst_d = '0;
      db_o_d   = '0;
      unique case (state_d)
         WR_LO: begin
            cs_n_d = 1'b0;
            wr_n_d = 1'b0;
            oe_d   = 1'b1;
            db_o_d = word_sel_d ? DATA_W'(cfg_d[15:0]) : DATA_W'(cfg_d[31:16]);
         end
         WR_HI:   cs_n_d = 1'b0;
         CONV:    convst_d = '1;
         RD_LO: begin
            cs_n_d = 1'b0;
            rd_n_d = 1'b0;
         end
         RD_HI:   cs_n_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         ph_cnt      <= '0;
         to_cnt      <= '0;
         idx_q       <= '0;
         word_sel_q  <= 1'b0;
         cfg_q       <= '0;
         busy_s1     <= 1'b0;
         busy_s2     <= 1'b0;
         CS_N        <= 1'b1;
         WR_N        <= 1'b1;
         RD_N        <= 1'b1;
         CONVST      <= '0;
         DB_OE       <= 1'b0;
         DB_O        <= '0;
         smp_valid   <= 1'b0;
         smp_data    <= '0;
         smp_idx     <= '0;
         frame_done  <= 1'b0;
         timeout_err <= 1'b0;
         ctrl_busy   <= 1'b0;
      end else begin
         busy_s1    <= BUSY;
         busy_s2    <= busy_s1;
         state_q    <= state_d;
         idx_q      <= idx_d;
         word_sel_q <= word_sel_d;
         cfg_q      <= cfg_d;

         // Phase counter restarts on every state change and saturates.
         if (state_d != state_q)  ph_cnt <= '0;
         else if (ph_cnt != '1)   ph_cnt <= ph_cnt + 1'b1;

         // The timeout count is zero on the first WAIT_HI cycle.
         // It then runs across WAIT_HI and WAIT_LO without restarting.
         if (state_q != WAIT_HI && state_q != WAIT_LO) to_cnt <= '0;
         else if (to_cnt != '1)                        to_cnt <= to_cnt + 1'b1;

         // DB_I is sampled at the end of the last RD_LO cycle.
         // The sample is presented during the first RD_HI cycle.
         if (cap) begin
            smp_data <= DB_I;
            smp_idx  <= idx_q;
         end
         smp_valid   <= cap;
         frame_done  <= done;
         timeout_err <= to_hit;

         CS_N      <= cs_n_d;
         WR_N      <= wr_n_d;
         RD_N      <= rd_n_d;
         CONVST    <= convst_d;
         DB_OE     <= oe_d;
         DB_O      <= db_o_d;
         ctrl_busy <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_adc_par_reader.sv
// tb_adc_par_reader
//
// Scoreboarded bench for adc_par_reader.
// It drives two instances:
// - u_dut: default parameters (4 pairs).
// - u_min: minimum configuration (1 pair, 1-cycle CONVST).
// Each instance gets a small ADC model. That model returns base+k on the
// k-th read of a chip-select window.
module tb_adc_par_reader;

   localparam int DW = 16;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- main instance ----------------
   logic          cfg_req  = 1'b0;
   logic [31:0]   cfg_word = '0;
   logic          conv_req = 1'b0;
   logic          BUSY     = 1'b0;
   logic          ctrl_busy, CS_N, WR_N, RD_N, DB_OE;
   logic [3:0]    CONVST;
   logic [DW-1:0] DB_I, DB_O, smp_data;
   logic          smp_valid, frame_done, timeout_err;
   logic [2:0]    smp_idx;

   adc_par_reader u_dut (
      .CLK(CLK), .RST(RST), .cfg_req(cfg_req), .cfg_word(cfg_word),
      .conv_req(conv_req), .ctrl_busy(ctrl_busy), .CS_N(CS_N), .WR_N(WR_N),
      .RD_N(RD_N), .CONVST(CONVST), .BUSY(BUSY), .DB_I(DB_I), .DB_O(DB_O),
      .DB_OE(DB_OE), .smp_valid(smp_valid), .smp_data(smp_data),
      .smp_idx(smp_idx), .frame_done(frame_done), .timeout_err(timeout_err)
   );

   // ---------------- minimum instance ----------------
   logic          cfg_req_m  = 1'b0;
   logic [31:0]   cfg_word_m = '0;
   logic          conv_req_m = 1'b0;
   logic          BUSY_m     = 1'b0;
   logic          ctrl_busy_m, CS_N_m, WR_N_m, RD_N_m, DB_OE_m;
   logic [0:0]    CONVST_m;
   logic [DW-1:0] DB_I_m, DB_O_m, smp_data_m;
   logic          smp_valid_m, frame_done_m, timeout_err_m;
   logic [0:0]    smp_idx_m;

   adc_par_reader #(.NUM_PAIRS(1), .CONVST_CYC(1)) u_min (
      .CLK(CLK), .RST(RST), .cfg_req(cfg_req_m), .cfg_word(cfg_word_m),
      .conv_req(conv_req_m), .ctrl_busy(ctrl_busy_m), .CS_N(CS_N_m),
      .WR_N(WR_N_m), .RD_N(RD_N_m), .CONVST(CONVST_m), .BUSY(BUSY_m),
      .DB_I(DB_I_m), .DB_O(DB_O_m), .DB_OE(DB_OE_m), .smp_valid(smp_valid_m),
      .smp_data(smp_data_m), .smp_idx(smp_idx_m), .frame_done(frame_done_m),
      .timeout_err(timeout_err_m)
   );

   // ---------------- ADC models ----------------
   int   rd_seen = 0, rd_seen_m = 0;
   logic rd_prev = 1'b1, rd_prev_m = 1'b1;

   always @(posedge CLK) begin
      rd_prev   <= RD_N;
      rd_prev_m <= RD_N_m;
      if (CS_N)                   rd_seen <= 0;
      else if (RD_N && !rd_prev)  rd_seen <= rd_seen + 1;
      if (CS_N_m)                     rd_seen_m <= 0;
      else if (RD_N_m && !rd_prev_m)  rd_seen_m <= rd_seen_m + 1;
   end
   assign DB_I   = 16'h1000 + 16'(rd_seen);
   assign DB_I_m = 16'h2000 + 16'(rd_seen_m);

   // ---------------- scoreboard ----------------
   logic [31:0] wr_q[$];     // {low length, word} per config bus write
   logic [19:0] exp_q[$];    // {idx, data} per sample, main instance
   logic [7:0]  evt_q[$];    // "D" frame_done, "T" timeout_err
   logic [19:0] exp_m_q[$];
   logic [7:0]  evt_m_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic extra(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h required=none", name, act);
   endtask

   // Monitor: pops expectations whenever a DUT presents an output event.
   int            wr_len  = 0;
   logic [DW-1:0] wr_word = '0;
   always @(negedge CLK) begin
      if (RST) begin
         wr_len = 0;
      end else begin
         check("bus_rules", {!WR_N && !RD_N, DB_OE}, {1'b0, !WR_N});
         check("bus_rules_min", {!WR_N_m && !RD_N_m, DB_OE_m}, {1'b0, !WR_N_m});
         if (!WR_N) begin
            wr_len++;
            wr_word = DB_O;
         end else if (wr_len > 0) begin
            if (wr_q.size() == 0) extra("wr_extra", {16'(wr_len), wr_word});
            else check("wr_word", {16'(wr_len), wr_word}, wr_q.pop_front());
            wr_len = 0;
         end
         if (smp_valid) begin
            if (exp_q.size() == 0) extra("smp_extra", {1'b0, smp_idx, smp_data});
            else check("smp", {1'b0, smp_idx, smp_data}, exp_q.pop_front());
         end
         if (frame_done) begin
            if (evt_q.size() == 0) extra("frame_done_extra", 8'h44);
            else check("evt_done", 8'h44, evt_q.pop_front());
         end
         if (timeout_err) begin
            if (evt_q.size() == 0) extra("timeout_extra", 8'h54);
            else check("evt_timeout", 8'h54, evt_q.pop_front());
         end
         if (smp_valid_m) begin
            if (exp_m_q.size() == 0) extra("smp_min_extra", {3'b0, smp_idx_m, smp_data_m});
            else check("smp_min", {3'b0, smp_idx_m, smp_data_m}, exp_m_q.pop_front());
         end
         if (frame_done_m) begin
            if (evt_m_q.size() == 0) extra("frame_done_min_extra", 8'h44);
            else check("evt_done_min", 8'h44, evt_m_q.pop_front());
         end
         if (timeout_err_m) extra("timeout_min_extra", 8'h54);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_reset_vals(input string name);
      check(name, {CS_N, WR_N, RD_N, CONVST, DB_OE, DB_O, smp_valid, smp_data,
                   smp_idx, frame_done, timeout_err, ctrl_busy}, {3'b111, 44'd0});
      check({name, "_min"}, {CS_N_m, WR_N_m, RD_N_m, CONVST_m, DB_OE_m, DB_O_m,
                   smp_valid_m, smp_data_m, smp_idx_m, frame_done_m,
                   timeout_err_m, ctrl_busy_m}, {3'b111, 39'd0});
   endtask

   task automatic check_queues(input string name);
      check({name, "_wr_left"}, wr_q.size(), 0);
      check({name, "_smp_left"}, exp_q.size(), 0);
      check({name, "_evt_left"}, evt_q.size(), 0);
      check({name, "_smp_min_left"}, exp_m_q.size(), 0);
      check({name, "_evt_min_left"}, evt_m_q.size(), 0);
   endtask

   // Issue a config write (optionally with a competing conv_req).
   // Measures busy length, CS_N and any CONVST activity.
   task automatic run_cfg(input logic [31:0] w, input bit with_conv, input string name);
      int n, cs_bad, cv_seen;
      wr_q.push_back({16'd3, w[31:16]});
      wr_q.push_back({16'd3, w[15:0]});
      @(negedge CLK);
      cfg_word = w;
      cfg_req  = 1'b1;
      conv_req = with_conv;
      @(negedge CLK);
      cfg_req  = 1'b0;
      conv_req = 1'b0;
      n = 0; cs_bad = 0; cv_seen = 0;
      while (ctrl_busy && n < 100) begin
         n++;
         if (CS_N) cs_bad++;
         if (|CONVST) cv_seen++;
         @(negedge CLK);
      end
      check({name, "_busy_len"}, n, 10);
      check({name, "_cs_low"}, cs_bad, 0);
      check({name, "_no_convst"}, cv_seen, 0);
      repeat (3) @(negedge CLK);
      check({name, "_idle"}, {ctrl_busy, CS_N, |CONVST}, 3'b010);
      check_queues(name);
   endtask

   // Conversion + frame read.
   // BUSY rises about 2 cycles after CONVST falls and is held for 50 cycles.
   // If poke is set, conv_req is pulsed again in the middle of the read.
   task automatic run_frame(input bit mn, input bit poke, input string name);
      int n;
      @(negedge CLK);
      if (mn) conv_req_m = 1'b1;
      else    conv_req   = 1'b1;
      @(negedge CLK);
      conv_req   = 1'b0;
      conv_req_m = 1'b0;
      n = 0;
      while ((mn ? CONVST_m[0] : &CONVST) && n < 100) begin
         n++;
         @(negedge CLK);
      end
      check({name, "_convst_width"}, n, mn ? 1 : 4);
      @(negedge CLK);
      if (mn) BUSY_m = 1'b1;
      else    BUSY   = 1'b1;
      repeat (50) @(negedge CLK);
      BUSY   = 1'b0;
      BUSY_m = 1'b0;
      if (poke) begin
         repeat (20) @(negedge CLK);
         check({name, "_mid_read"}, {ctrl_busy, CS_N}, 2'b10);
         conv_req = 1'b1;
         @(negedge CLK);
         conv_req = 1'b0;
      end
      n = 0;
      while ((mn ? ctrl_busy_m : ctrl_busy) && n < 500) begin
         n++;
         @(negedge CLK);
      end
      check({name, "_end"}, mn ? ctrl_busy_m : ctrl_busy, 1'b0);
      repeat (3) @(negedge CLK);
      check({name, "_idle"}, {ctrl_busy, |CONVST, ctrl_busy_m, CONVST_m}, 4'b0000);
      check_queues(name);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n, falls;
      logic prev;

      #2 RST = 1'b1;
      #1 check_reset_vals("reset_vals");
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      check_reset_vals("after_release");

      // Config write.
      run_cfg(32'hA5A5_0F0F, 1'b0, "cfg");

      // Simultaneous requests: config wins, no conversion.
      run_cfg(32'h1234_5678, 1'b1, "arb");

      // Full frame, with a conv_req pulse dropped mid-read.
      for (int i = 0; i < 8; i++) exp_q.push_back({4'(i), 16'h1000 + 16'(i)});
      evt_q.push_back(8'h44);
      run_frame(1'b0, 1'b1, "frame");

      // BUSY timeout.
      evt_q.push_back(8'h54);
      @(negedge CLK);
      conv_req = 1'b1;
      @(negedge CLK);
      conv_req = 1'b0;
      n = 0;
      while (&CONVST && n < 100) begin
         n++;
         @(negedge CLK);
      end
      n = 0;
      while (!timeout_err && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      check("timeout_latency", n, 1024);
      check("timeout_pins", {CS_N, ctrl_busy, smp_valid}, 3'b100);
      @(negedge CLK);
      check("timeout_after", {timeout_err, ctrl_busy, CS_N}, 3'b001);
      repeat (2) @(negedge CLK);
      check_queues("timeout");

      // Reset during the third RD_LO.
      exp_q.push_back({4'd0, 16'h1000});
      exp_q.push_back({4'd1, 16'h1001});
      @(negedge CLK);
      conv_req = 1'b1;
      @(negedge CLK);
      conv_req = 1'b0;
      n = 0;
      while (&CONVST && n < 100) begin
         n++;
         @(negedge CLK);
      end
      @(negedge CLK);
      BUSY = 1'b1;
      repeat (50) @(negedge CLK);
      BUSY = 1'b0;
      falls = 0;
      prev  = 1'b1;
      n     = 0;
      while (falls < 3 && n < 300) begin
         @(negedge CLK);
         n++;
         if (!RD_N && prev) falls++;
         prev = RD_N;
      end
      check("rd_lo3_reached", falls, 3);
      #2 RST = 1'b1;
      #1 check_reset_vals("reset_mid_frame");
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      check_queues("abort");

      // Fresh frame after the abort starts again at idx 0.
      for (int i = 0; i < 8; i++) exp_q.push_back({4'(i), 16'h1000 + 16'(i)});
      evt_q.push_back(8'h44);
      run_frame(1'b0, 1'b0, "refresh");

      // Minimum configuration.
      exp_m_q.push_back({4'd0, 16'h2000});
      exp_m_q.push_back({4'd1, 16'h2001});
      evt_m_q.push_back(8'h44);
      run_frame(1'b1, 1'b0, "min");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_par_reader.md
ADC_PAR_READER -- requirements
Module: adc_par_reader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_PAIRS, 4, number of channel pairs (1..4); 2*NUM_PAIRS words per frame.
- DATA_W, 16, data bus width.
- CONVST_CYC, 4, CONVST high width in CLK cycles.
- WRL_CYC, 3, WR_N low width.
- RDL_CYC, 3, RD_N low width.
- RDH_CYC, 2, RD_N/WR_N high gap.
- TIMEOUT_CYC, 1024, BUSY wait limit.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-high reset.
- cfg_req  in  1  start config write.
- cfg_word  in  32  config register value.
- conv_req  in  1  start conversion and read frame.
- ctrl_busy  out  1  controller not idle.
- CS_N  out  1  ADC chip select.
- WR_N  out  1  ADC write strobe.
- RD_N  out  1  ADC read strobe.
- CONVST  out  NUM_PAIRS  convert start, one per pair.
- BUSY  in  1  ADC busy, asynchronous.
- DB_I  in  DATA_W  bus input.
- DB_O  out  DATA_W  bus output.
- DB_OE  out  1  bus output enable.
- smp_valid  out  1  sample strobe.
- smp_data  out  DATA_W  sample value.
- smp_idx  out  $clog2(2*NUM_PAIRS)  word index; minimum width 1.
- frame_done  out  1  frame-complete pulse.
- timeout_err  out  1  BUSY timeout pulse.

Function
REQ-003 The FSM SHALL have these states: IDLE, WR_LO, WR_HI, CONV, WAIT_HI, WAIT_LO, RD_LO, RD_HI.
REQ-004 The block SHALL accept requests only in IDLE; if both are high in the same cycle, cfg_req wins; requests outside IDLE are dropped, with no queuing.
REQ-005 On cfg_req acceptance, the block SHALL latch cfg_word and drive CS_N low for the whole transaction.
REQ-006 Config write sequencing SHALL be:
- Word 0 = cfg_word[31:16], then word 1 = cfg_word[15:0].
- Each word: WR_LO for WRL_CYC cycles with WR_N=0, DB_OE=1, DB_O=word.
- Each word is followed by WR_HI for RDH_CYC cycles with WR_N=1 and DB_OE=0.
- After the second WR_HI: CS_N=1, return to IDLE.
REQ-007 On conv_req acceptance, the block SHALL drive all CONVST bits high for exactly CONVST_CYC cycles (CONV), then low, and enter WAIT_HI.
REQ-008 BUSY SHALL pass through a 2-flop synchronizer; all BUSY decisions use the synchronized value.
REQ-009 BUSY wait handling SHALL be:
- WAIT_HI exits when synced BUSY=1.
- WAIT_LO exits when synced BUSY=0.
- One timeout counter, cleared on WAIT_HI entry, spans both states.
REQ-010 Timeout SHALL be handled as follows:
- Trigger: counter reaches TIMEOUT_CYC.
- Response: timeout_err pulses 1 cycle, CS_N=1, return to IDLE.
- No smp_valid and no frame_done.
REQ-011 Read sequence: on WAIT_LO exit, the block SHALL drive CS_N=0 and, for idx = 0 .. 2*NUM_PAIRS-1:
- RD_LO for RDL_CYC cycles with RD_N=0.
- DB_I is registered on the last RD_LO cycle.
- RD_HI follows for RDH_CYC cycles with RD_N=1.
REQ-012 smp_valid SHALL pulse 1 cycle on the first RD_HI cycle of each word, with smp_data = the registered word and smp_idx = idx; smp_data and smp_idx hold until the next pulse.
REQ-013 After the final RD_HI, frame_done SHALL pulse 1 cycle, CS_N SHALL go to 1, and the FSM SHALL return to IDLE; smp_idx wraps to 0 for the next frame.
REQ-014 WR_N and RD_N SHALL never both be 0; DB_OE SHALL be 1 only in WR_LO.
REQ-015 ctrl_busy SHALL equal (state != IDLE).
REQ-016 All strobe and select outputs SHALL be registered (glitch-free).
REQ-017 Counters SHALL be sized to the largest of their parameters and saturate rather than wrap.

Reset
REQ-018 While RST=1, regardless of state, outputs SHALL immediately take these values:
- CS_N=1, WR_N=1, RD_N=1.
- CONVST=0, DB_OE=0, DB_O=0.
- smp_valid=0, smp_data=0, smp_idx=0.
- frame_done=0, timeout_err=0, ctrl_busy=0.
- FSM=IDLE; counters and synchronizer cleared.
REQ-019 Reset mid-transaction SHALL abort with no frame_done or timeout_err; the first request after RST release SHALL start a fresh sequence from word/idx 0.

Verification
REQ-020 Config write: cfg_req with cfg_word=32'hA5A5_0F0F -> two 3-cycle WR_N lows; DB_O=16'hA5A5 then 16'h0F0F; DB_OE high only then; CS_N low throughout; 10 cycles total busy.
REQ-021 Full frame (NUM_PAIRS=4): BUSY high 2 cycles after CONVST fall, low 50 cycles later, DB_I=16'h1000+idx -> 8 smp_valid pulses, idx 0..7, data 16'h1000..16'h1007, then exactly one frame_done.
REQ-022 Timeout: BUSY held 0 after conv_req -> timeout_err pulses exactly 1024 cycles after WAIT_HI entry; no smp_valid; CS_N=1; ctrl_busy=0 the next cycle.
REQ-023 Arbitration: cfg_req and conv_req in the same cycle -> only the config write occurs; conv_req pulsed during a read frame -> ignored, still exactly one frame_done.
REQ-024 Reset mid-frame: RST during the 3rd RD_LO -> all outputs at reset values within the same cycle, no frame_done; the next conv_req yields idx 0..7 again.
REQ-025 Minimum configuration: NUM_PAIRS=1 -> CONVST width 1, 2 samples with idx 0,1, then frame_done.
